// File: rtl/enemy_fire_pkg.sv
// Shared types and constants for the enemy fire scheduler.
// Holds the FSM state type, the LFSR feedback mask and the shooter-index width helper.
package enemy_fire_pkg;

    typedef enum logic [1:0] {
        StCooldown,
        StPick,
        StRequest,
        StFlight
    } state_e;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fire_lfsr16.sv
// Free-running 16-bit Galois LFSR used to randomise the shooter scan start.
// Advances every clock; SEED must be non-zero.
module fire_lfsr16
    import enemy_fire_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_POLY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Decides when and which living enemy fires, and drives the projectile launch request.
// Optional alternating short-gap bursts at high levels under `ENEMY_FIRE_BURST_EN.
module enemy_fire_scheduler
    import enemy_fire_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES          = 8,
    parameter int unsigned BASE_COOLDOWN_FRAMES = 90,
    parameter int unsigned LEVEL_COOLDOWN_STEP  = 8,
    parameter int unsigned MIN_COOLDOWN_FRAMES  = 20,
    parameter int unsigned X_OFFSET             = 16,
    parameter int unsigned Y_OFFSET             = 32,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
`ifdef ENEMY_FIRE_BURST_EN
    ,
    parameter int unsigned BURST_MIN_LEVEL      = 5,
    parameter int unsigned BURST_GAP_FRAMES     = 6
`endif
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   startOfFrame,
    input  logic                                   endLevel,
    input  logic [3:0]                             level,
    input  logic [NUM_ENEMIES-1:0]                 enemyAlive,
    input  logic [NUM_ENEMIES*11-1:0]              enemyX,
    input  logic [NUM_ENEMIES*11-1:0]              enemyY,
    input  logic                                   beingShot,
    output logic                                   shootRequestEnemy,
    output logic [10:0]                            initial_x,
    output logic [10:0]                            initial_y,
    output logic [idx_width(NUM_ENEMIES)-1:0]      shooterIndex,
    output logic                                   cooldownActive
);

    localparam int unsigned IDX_W   = idx_width(NUM_ENEMIES);
    localparam logic [7:0]  BASE8   = 8'(BASE_COOLDOWN_FRAMES);
    localparam logic [7:0]  MIN8    = 8'(MIN_COOLDOWN_FRAMES);
    localparam logic [11:0] CD_SPAN = 12'(BASE_COOLDOWN_FRAMES - MIN_COOLDOWN_FRAMES);

    state_e             state_q, state_d;
    logic [7:0]         counter_q, counter_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [10:0]        ix_q, ix_d;
    logic [10:0]        iy_q, iy_d;
    logic               shoot_q, shoot_d;

    logic [15:0]        lfsr_value;
    logic [11:0]        lvl_prod;
    logic [7:0]         cd;
    logic [7:0]         reload_flight;
    logic [IDX_W-1:0]   pick_idx;
    logic [10:0]        enemy_x_arr [NUM_ENEMIES];
    logic [10:0]        enemy_y_arr [NUM_ENEMIES];
    logic               unused_lfsr_bits;

    fire_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value[15:IDX_W];

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_unpack
        assign enemy_x_arr[i] = enemyX[i*11 +: 11];
        assign enemy_y_arr[i] = enemyY[i*11 +: 11];
    end

    // Clamp before subtracting so high levels never underflow the 8-bit cooldown.
    assign lvl_prod = 12'(level) * 12'(LEVEL_COOLDOWN_STEP);
    assign cd       = (lvl_prod >= CD_SPAN) ? MIN8 : (BASE8 - lvl_prod[7:0]);
    assign pick_idx = start_q + k_q;

`ifdef ENEMY_FIRE_BURST_EN
    logic burst_q, burst_d;
    logic burst_level;

    assign burst_level   = ({28'd0, level} >= BURST_MIN_LEVEL);
    // burst_q set means the shot just finished was the short-gap one.
    assign reload_flight = (burst_level && !burst_q) ? 8'(BURST_GAP_FRAMES) : cd;

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= 1'b0;
        end else begin
            burst_q <= burst_d;
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (endLevel) begin
            burst_d = 1'b0;
        end else if (state_q == StFlight && !beingShot) begin
            burst_d = burst_level && !burst_q;
        end
    end
`else
    assign reload_flight = cd;
`endif

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        start_d   = start_q;
        k_d       = k_q;
        idx_d     = idx_q;
        ix_d      = ix_q;
        iy_d      = iy_q;
        shoot_d   = shoot_q;

        if (endLevel) begin
            state_d   = StCooldown;
            counter_d = cd;
            shoot_d   = 1'b0;
            k_d       = '0;
        end else begin
            unique case (state_q)
                StCooldown: begin
                    if (startOfFrame) begin
                        if (counter_q < 8'd2) begin
                            state_d = StPick;
                            start_d = lfsr_value[IDX_W-1:0];
                            k_d     = '0;
                        end else begin
                            counter_d = counter_q - 8'd1;
                        end
                    end
                end
                StPick: begin
                    if (enemyAlive[pick_idx]) begin
                        ix_d    = enemy_x_arr[pick_idx] + 11'(X_OFFSET);
                        iy_d    = enemy_y_arr[pick_idx] + 11'(Y_OFFSET);
                        idx_d   = pick_idx;
                        shoot_d = 1'b1;
                        state_d = StRequest;
                    end else if (k_q == '1) begin
                        counter_d = cd;
                        state_d   = StCooldown;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                StRequest: begin
                    // The handshake wins over a same-cycle death of the shooter.
                    if (beingShot) begin
                        shoot_d = 1'b0;
                        state_d = StFlight;
                    end else if (!enemyAlive[idx_q]) begin
                        shoot_d = 1'b0;
                        state_d = StPick;
                        start_d = lfsr_value[IDX_W-1:0];
                        k_d     = '0;
                    end
                end
                StFlight: begin
                    if (!beingShot) begin
                        counter_d = reload_flight;
                        state_d   = StCooldown;
                    end
                end
                default: begin
                    state_d = StCooldown;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StCooldown;
            counter_q <= cd;
            start_q   <= '0;
            k_q       <= '0;
            idx_q     <= '0;
            ix_q      <= '0;
            iy_q      <= '0;
            shoot_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            start_q   <= start_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
            ix_q      <= ix_d;
            iy_q      <= iy_d;
            shoot_q   <= shoot_d;
        end
    end

    assign shootRequestEnemy = shoot_q;
    assign initial_x         = ix_q;
    assign initial_y         = iy_q;
    assign shooterIndex      = idx_q;
    assign cooldownActive    = (state_q == StCooldown);

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler: cooldown timing, pick, handshake, abort paths.
// Burst-gap expectations follow `ENEMY_FIRE_BURST_EN when defined.
module tb_enemy_fire_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        endLevel;
    logic [3:0]  level;
    logic [7:0]  enemyAlive;
    logic [87:0] enemyX;
    logic [87:0] enemyY;
    logic        beingShot;
    logic        shootRequestEnemy;
    logic [10:0] initial_x;
    logic [10:0] initial_y;
    logic [2:0]  shooterIndex;
    logic        cooldownActive;

    logic        echo_en;
    logic        bs_manual;
    logic [2:0]  echo = 3'b000;
    logic [10:0] ex [8];
    logic [10:0] ey [8];

    int errors = 0;
    int checks = 0;

    enemy_fire_scheduler u_dut (
        .clk               (clk),
        .reset             (reset),
        .startOfFrame      (startOfFrame),
        .endLevel          (endLevel),
        .level             (level),
        .enemyAlive        (enemyAlive),
        .enemyX            (enemyX),
        .enemyY            (enemyY),
        .beingShot         (beingShot),
        .shootRequestEnemy (shootRequestEnemy),
        .initial_x         (initial_x),
        .initial_y         (initial_y),
        .shooterIndex      (shooterIndex),
        .cooldownActive    (cooldownActive)
    );

    always #5 clk = ~clk;

    // Projectile stand-in: beingShot follows the request three cycles late.
    always @(posedge clk) echo <= {echo[1:0], shootRequestEnemy};
    assign beingShot = echo_en ? echo[2] : bs_manual;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic end_level();
        endLevel = 1'b1;
        step();
        endLevel = 1'b0;
    endtask

    // Pulses frames until the request rises; frames = -1 when the budget runs out.
    task automatic wait_request(input int max_frames, output int frames);
        bit seen;
        seen   = 1'b0;
        frames = 0;
        while (!seen && frames < max_frames) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            frames++;
            for (int c = 0; c < 10 && !seen; c++) begin
                step();
                seen = shootRequestEnemy;
            end
        end
        if (!seen) frames = -1;
    endtask

    task automatic wait_cooldown(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            step();
            ok = cooldownActive;
        end
    endtask

    task automatic test_reset();
        level        = 4'd0;
        enemyAlive   = 8'hFF;
        startOfFrame = 1'b0;
        endLevel     = 1'b0;
        echo_en      = 1'b1;
        bs_manual    = 1'b0;
        reset        = 1'b1;
        step();
        step();
        checks++; if (shootRequestEnemy !== 1'b0) begin errors++;
            $display("FAIL reset_req: got %b want 0", shootRequestEnemy); end
        checks++; if (initial_x !== 11'd0) begin errors++;
            $display("FAIL reset_x: got %0d want 0", initial_x); end
        checks++; if (initial_y !== 11'd0) begin errors++;
            $display("FAIL reset_y: got %0d want 0", initial_y); end
        checks++; if (shooterIndex !== 3'd0) begin errors++;
            $display("FAIL reset_idx: got %0d want 0", shooterIndex); end
        checks++; if (cooldownActive !== 1'b1) begin errors++;
            $display("FAIL reset_cd: got %b want 1", cooldownActive); end
        reset = 1'b0;
    endtask

    task automatic test_first_shot();
        int f;
        bit ok;
        wait_request(100, f);
        checks++; if (f !== 90) begin errors++;
            $display("FAIL first_gap: got %0d frames want 90", f); end
        checks++; if (initial_x !== 11'(ex[shooterIndex] + 11'd16)) begin errors++;
            $display("FAIL first_x: got %0d want %0d", initial_x, ex[shooterIndex] + 11'd16); end
        checks++; if (initial_y !== 11'(ey[shooterIndex] + 11'd32)) begin errors++;
            $display("FAIL first_y: got %0d want %0d", initial_y, ey[shooterIndex] + 11'd32); end
        wait_cooldown(ok);
        checks++; if (ok !== 1'b1 || shootRequestEnemy !== 1'b0) begin errors++;
            $display("FAIL first_flight_done: got cd=%b req=%b want 1/0", ok, shootRequestEnemy); end
    endtask

    task automatic test_cooldown_levels();
        int f;
        level = 4'd15;
        end_level();
        wait_request(40, f);
        checks++; if (f !== 20) begin errors++;
            $display("FAIL clamp_l15: got %0d frames want 20", f); end
        level = 4'd5;
        end_level();
        wait_request(60, f);
        checks++; if (f !== 50) begin errors++;
            $display("FAIL cd_l5: got %0d frames want 50", f); end
    endtask

    task automatic test_single_alive();
        int f;
        level      = 4'd15;
        enemyAlive = 8'b0000_0100;
        for (int r = 0; r < 2; r++) begin
            end_level();
            wait_request(30, f);
            checks++; if (f !== 20) begin errors++;
                $display("FAIL single_gap%0d: got %0d want 20", r, f); end
            checks++; if (shooterIndex !== 3'd2) begin errors++;
                $display("FAIL single_idx%0d: got %0d want 2", r, shooterIndex); end
            // X 2040+16 and Y 2030+32 both wrap in 11 bits.
            checks++; if (initial_x !== 11'd8 || initial_y !== 11'd14) begin errors++;
                $display("FAIL single_xy%0d: got %0d,%0d want 8,14", r, initial_x, initial_y); end
        end
    endtask

    task automatic test_no_alive();
        int f;
        enemyAlive = 8'h00;
        end_level();
        for (int s = 0; s < 19; s++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step();
        end
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        checks++; if (cooldownActive !== 1'b0) begin errors++;
            $display("FAIL none_enter_pick: got cd=%b want 0", cooldownActive); end
        repeat (7) step();
        checks++; if (cooldownActive !== 1'b0 || shootRequestEnemy !== 1'b0) begin errors++;
            $display("FAIL none_pick8: got cd=%b req=%b want 0/0", cooldownActive, shootRequestEnemy); end
        step();
        checks++; if (cooldownActive !== 1'b1 || shootRequestEnemy !== 1'b0) begin errors++;
            $display("FAIL none_back: got cd=%b req=%b want 1/0", cooldownActive, shootRequestEnemy); end
        enemyAlive = 8'hFF;
        wait_request(30, f);
        checks++; if (f !== 20) begin errors++;
            $display("FAIL none_reload: got %0d frames want 20", f); end
    endtask

    task automatic test_hold_request();
        int f;
        int bad;
        bit seen;
        logic [10:0] x0, y0;
        logic [2:0]  i0;
        echo_en   = 1'b0;
        bs_manual = 1'b0;
        end_level();
        wait_request(30, f);
        x0  = initial_x;
        y0  = initial_y;
        i0  = shooterIndex;
        bad = 0;
        repeat (40) begin
            step();
            if (shootRequestEnemy !== 1'b1 || initial_x !== x0 || initial_y !== y0) bad++;
        end
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
        enemyAlive[i0] = 1'b0;
        step();
        checks++; if (shootRequestEnemy !== 1'b0) begin errors++;
            $display("FAIL kill_drop: got req=%b want 0", shootRequestEnemy); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            seen = shootRequestEnemy;
        end
        checks++; if (seen !== 1'b1 || shooterIndex === i0) begin errors++;
            $display("FAIL repick: got req=%b idx=%0d want 1, idx!=%0d", seen, shooterIndex, i0); end
        checks++; if (initial_x !== 11'(ex[shooterIndex] + 11'd16)) begin errors++;
            $display("FAIL repick_x: got %0d want %0d", initial_x, ex[shooterIndex] + 11'd16); end
        enemyAlive = 8'hFF;
    endtask

    task automatic test_end_level();
        int f;
        end_level();
        checks++; if (shootRequestEnemy !== 1'b0 || cooldownActive !== 1'b1) begin errors++;
            $display("FAIL el_req: got req=%b cd=%b want 0/1", shootRequestEnemy, cooldownActive); end
        wait_request(30, f);
        checks++; if (f !== 20) begin errors++;
            $display("FAIL el_req_gap: got %0d frames want 20", f); end
        bs_manual = 1'b1;
        step();
        checks++; if (shootRequestEnemy !== 1'b0 || cooldownActive !== 1'b0) begin errors++;
            $display("FAIL flight_enter: got req=%b cd=%b want 0/0", shootRequestEnemy, cooldownActive); end
        end_level();
        checks++; if (cooldownActive !== 1'b1 || shootRequestEnemy !== 1'b0) begin errors++;
            $display("FAIL el_flight: got cd=%b req=%b want 1/0", cooldownActive, shootRequestEnemy); end
        bs_manual = 1'b0;
        wait_request(30, f);
        checks++; if (f !== 20) begin errors++;
            $display("FAIL el_flight_gap: got %0d frames want 20", f); end
        end_level();
        echo_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int f;
        bit ok;
        int exp_gap [3];
`ifdef ENEMY_FIRE_BURST_EN
        exp_gap = '{6, 42, 6};
`else
        exp_gap = '{42, 42, 42};
`endif
        level = 4'd6;
        end_level();
        wait_request(60, f);
        checks++; if (f !== 42) begin errors++;
            $display("FAIL b2b_gap0: got %0d frames want 42", f); end
        for (int i = 0; i < 3; i++) begin
            wait_cooldown(ok);
            wait_request(60, f);
            checks++; if (!ok || f !== exp_gap[i]) begin errors++;
                $display("FAIL b2b_gap%0d: got %0d frames (flight ok=%b) want %0d",
                         i + 1, f, ok, exp_gap[i]); end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (shootRequestEnemy !== 1'b0 || cooldownActive !== 1'b1) begin errors++;
            $display("FAIL mid_reset_ctl: got req=%b cd=%b want 0/1", shootRequestEnemy, cooldownActive); end
        checks++; if (initial_x !== 11'd0 || initial_y !== 11'd0 || shooterIndex !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_data: got %0d,%0d,%0d want 0,0,0",
                     initial_x, initial_y, shooterIndex); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ex[i] = 11'(100 + i * 37);
            ey[i] = 11'(300 + i * 53);
        end
        ex[2] = 11'd2040;
        ey[2] = 11'd2030;
        for (int i = 0; i < 8; i++) begin
            enemyX[i*11 +: 11] = ex[i];
            enemyY[i*11 +: 11] = ey[i];
        end

        test_reset();
        test_first_shot();
        test_cooldown_levels();
        test_single_alive();
        test_no_alive();
        test_hold_request();
        test_end_level();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
